// File: rtl/fetch_stage.sv
// Purpose : RV32I instruction-fetch stage; owns the PC, feeds the ROM, fills IF/ID.
// Latency : 1 cycle from pc_o to the IF/ID outputs (ROM is combinational).
// Backpr. : stall_i freezes PC, IF/ID and counter; redirect_i overrides stall.
//
// Optional feature macro: FETCH_JAL_PREDECODE_EN
//   defined   -> jal is predecoded at fetch and followed immediately
//                (ifid_pred_taken_o marks the entry so EX skips its redirect)
//   undefined -> no predecode; ifid_pred_taken_o is always 0
//
// Ports:
//   clk, rst_n         clock (rising edge) / async active-low reset
//   stall_i            hold PC and IF/ID (load-use hazard)
//   redirect_i         control-flow change from EX; flushes IF/ID
//   redirect_pc_i      redirect target (low two bits ignored)
//   pc_o               current PC to the instruction ROM
//   instr_i            ROM word for pc_o, valid in the same cycle
//   ifid_valid_o       IF/ID holds a real instruction
//   ifid_pc_o          PC of the IF/ID instruction
//   ifid_pc4_o         ifid_pc_o + 4 (link value)
//   ifid_instr_o       IF/ID instruction word
//   ifid_pred_taken_o  fetch already followed a predicted jal
//   halted_o           fetch FSM is in HALT
//   fetch_count_o      count of valid entries loaded into IF/ID
module fetch_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
   parameter bit          HALT_ON_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   input  logic [31:0] instr_i,
   output logic        ifid_valid_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_pred_taken_o,
   output logic        halted_o,
   output logic [31:0] fetch_count_o
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_seq;
   logic [31:0] redirect_target;
   logic        zero_halt;
   logic        jal_take;
   logic [31:0] jal_target;
   logic [31:0] pc_next_fetch;

   // Sequential successor; 32-bit add wraps 0xFFFFFFFC to 0 naturally.
   assign pc_seq = pc + 32'd4;

   // PC is kept word aligned at all times.
   assign redirect_target = {redirect_pc_i[31:2], 2'b00};

   // All-zero word marks the end of the ROM image.
   assign zero_halt = HALT_ON_ZERO && (instr_i == 32'h0000_0000);

`ifdef FETCH_JAL_PREDECODE_EN
   logic [31:0] j_imm;

   // J-type immediate: imm[20|10:1|11|19:12], bit 0 implicitly zero.
   assign j_imm      = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
   assign jal_take   = (instr_i[6:0] == 7'b1101111);
   // A half-word-aligned target is not reachable without the C extension;
   // masking keeps the PC invariant and leaves the fault to later stages.
   assign jal_target = (pc + j_imm) & 32'hFFFF_FFFC;
`else
   assign jal_take   = 1'b0;
   assign jal_target = pc_seq;
`endif

   assign pc_next_fetch = jal_take ? jal_target : pc_seq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_RUN;
         pc                <= RESET_PC;
         ifid_valid_o      <= 1'b0;
         ifid_pc_o         <= 32'h0000_0000;
         ifid_pc4_o        <= 32'h0000_0000;
         ifid_instr_o      <= NOP_INSTR;
         ifid_pred_taken_o <= 1'b0;
         halted_o          <= 1'b0;
         fetch_count_o     <= 32'h0000_0000;
      end else begin
         case (state)
            ST_RUN: begin
               if (redirect_i) begin
                  // Flush: the word fetched this cycle is on the wrong path.
                  // Bubble PC fields are left as they were; only valid gates use.
                  pc                <= redirect_target;
                  ifid_valid_o      <= 1'b0;
                  ifid_instr_o      <= NOP_INSTR;
                  ifid_pred_taken_o <= 1'b0;
               end else if (stall_i) begin
                  // Hold everything.
                  pc <= pc;
               end else if (zero_halt) begin
                  ifid_valid_o      <= 1'b0;
                  ifid_instr_o      <= NOP_INSTR;
                  ifid_pred_taken_o <= 1'b0;
                  halted_o          <= 1'b1;
                  state             <= ST_HALT;
               end else begin
                  pc                <= pc_next_fetch;
                  ifid_valid_o      <= 1'b1;
                  ifid_pc_o         <= pc;
                  ifid_pc4_o        <= pc_seq;
                  ifid_instr_o      <= instr_i;
                  ifid_pred_taken_o <= jal_take;
                  fetch_count_o     <= fetch_count_o + 32'd1;
               end
            end

            ST_HALT: begin
               // Stall is meaningless here; only a redirect restarts fetch.
               if (redirect_i) begin
                  pc       <= redirect_target;
                  halted_o <= 1'b0;
                  state    <= ST_RUN;
               end
            end

            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   assign pc_o = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : directed self-checking bench for fetch_stage against a small ROM.
// Latency : checks sampled 1 time unit after each rising edge.
// Backpr. : exercises stall, redirect-over-stall, halt and resume.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] pc_o;
   logic [31:0] instr_i;
   logic        ifid_valid_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_pc4_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_pred_taken_o;
   logic        halted_o;
   logic [31:0] fetch_count_o;

   logic        ovr_en;
   logic [31:0] ovr_word;

   int n_cmp;
   int n_bad;

   fetch_stage dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall_i           (stall_i),
      .redirect_i        (redirect_i),
      .redirect_pc_i     (redirect_pc_i),
      .pc_o              (pc_o),
      .instr_i           (instr_i),
      .ifid_valid_o      (ifid_valid_o),
      .ifid_pc_o         (ifid_pc_o),
      .ifid_pc4_o        (ifid_pc4_o),
      .ifid_instr_o      (ifid_instr_o),
      .ifid_pred_taken_o (ifid_pred_taken_o),
      .halted_o          (halted_o),
      .fetch_count_o     (fetch_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM image: real words at a few addresses, filler addi elsewhere,
   // zero from address 100 upward.
   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a >= 32'd100) return 32'h0000_0000;
      case (a)
         32'd0:   return 32'h0050_0513;
         32'd12:  return 32'h0010_0793;
         32'd20:  return 32'h00a1_2023;
         32'd24:  return 32'h0011_2623;
         default: return 32'h0000_0013 | (a << 20);
      endcase
   endfunction

   always_comb instr_i = ovr_en ? ovr_word : rom(pc_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      rst_n         = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      ovr_en        = 1'b0;
      ovr_word      = 32'h0;

      // Reset state
      #12;
      chk("rst_pc",    pc_o, 32'h0);
      chk("rst_vld",   {31'b0, ifid_valid_o}, 32'h0);
      chk("rst_instr", ifid_instr_o, 32'h0000_0013);
      chk("rst_pc4",   ifid_pc4_o, 32'h0);
      chk("rst_ipc",   ifid_pc_o, 32'h0);
      chk("rst_halt",  {31'b0, halted_o}, 32'h0);
      chk("rst_cnt",   fetch_count_o, 32'h0);
      chk("rst_pred",  {31'b0, ifid_pred_taken_o}, 32'h0);
      rst_n = 1'b1;

      // First fetch
      step();
      chk("e1_instr", ifid_instr_o, 32'h0050_0513);
      chk("e1_ipc",   ifid_pc_o, 32'h0);
      chk("e1_pc4",   ifid_pc4_o, 32'h4);
      chk("e1_pc",    pc_o, 32'h4);
      chk("e1_vld",   {31'b0, ifid_valid_o}, 32'h1);
      step(); step(); step();
      chk("e4_cnt",   fetch_count_o, 32'd4);
      chk("e4_pc",    pc_o, 32'd16);
      step(); step();
      chk("pre_stall_pc", pc_o, 32'd24);

      // Stall two cycles at pc 24
      stall_i = 1'b1;
      step(); step();
      chk("stl_pc",    pc_o, 32'd24);
      chk("stl_ipc",   ifid_pc_o, 32'd20);
      chk("stl_instr", ifid_instr_o, 32'h00a1_2023);
      chk("stl_cnt",   fetch_count_o, 32'd6);
      stall_i = 1'b0;
      step();
      chk("rel_ipc",   ifid_pc_o, 32'd24);
      chk("rel_instr", ifid_instr_o, 32'h0011_2623);
      chk("rel_cnt",   fetch_count_o, 32'd7);

      // Run up to pc 52 (bounded)
      for (int i = 0; i < 20 && pc_o != 32'd52; i++) step();
      chk("reach52", pc_o, 32'd52);

      // Redirect wins over stall
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd12;
      step();
      chk("rd_pc",    pc_o, 32'd12);
      chk("rd_vld",   {31'b0, ifid_valid_o}, 32'h0);
      chk("rd_instr", ifid_instr_o, 32'h0000_0013);
      chk("rd_cnt",   fetch_count_o, 32'd13);
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      step();
      chk("rd2_ipc",   ifid_pc_o, 32'd12);
      chk("rd2_instr", ifid_instr_o, 32'h0010_0793);
      chk("rd2_vld",   {31'b0, ifid_valid_o}, 32'h1);
      chk("rd2_cnt",   fetch_count_o, 32'd14);

      // Halt on zero word at pc 100
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd100;
      step();
      chk("h_rd_pc", pc_o, 32'd100);
      redirect_i = 1'b0;
      step();
      chk("h_halt", {31'b0, halted_o}, 32'h1);
      chk("h_pc",   pc_o, 32'd100);
      chk("h_vld",  {31'b0, ifid_valid_o}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         stall_i = ~stall_i;
         step();
      end
      chk("h_stl_halt", {31'b0, halted_o}, 32'h1);
      chk("h_stl_pc",   pc_o, 32'd100);
      chk("h_stl_cnt",  fetch_count_o, 32'd14);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'd0;
      step();
      chk("res_halt", {31'b0, halted_o}, 32'h0);
      chk("res_pc",   pc_o, 32'h0);
      chk("res_vld",  {31'b0, ifid_valid_o}, 32'h0);
      redirect_i = 1'b0;
      stall_i    = 1'b0;

      // PC wrap
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      ovr_word      = 32'h0000_0013;
      ovr_en        = 1'b1;
      step();
      chk("wr_rd_pc", pc_o, 32'hFFFF_FFFC);
      redirect_i = 1'b0;
      step();
      chk("wr_pc",  pc_o, 32'h0);
      chk("wr_ipc", ifid_pc_o, 32'hFFFF_FFFC);
      chk("wr_pc4", ifid_pc4_o, 32'h0);
      ovr_en = 1'b0;

      // Unaligned redirect target
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_001E;
      step();
      chk("ua_pc", pc_o, 32'h0000_001C);

      // jal at pc 8
      redirect_pc_i = 32'd8;
      step();
      chk("j_rd_pc", pc_o, 32'd8);
      redirect_i = 1'b0;
      ovr_word   = 32'h0100_006F;
      ovr_en     = 1'b1;
      step();
      ovr_en = 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
      chk("j_pc",   pc_o, 32'd24);
      chk("j_pred", {31'b0, ifid_pred_taken_o}, 32'h1);
`else
      chk("j_pc",   pc_o, 32'd12);
      chk("j_pred", {31'b0, ifid_pred_taken_o}, 32'h0);
`endif
      chk("j_instr", ifid_instr_o, 32'h0100_006F);
      chk("j_ipc",   ifid_pc_o, 32'd8);
      chk("j_cnt",   fetch_count_o, 32'd16);

      // Asynchronous reset mid-operation
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_pc",    pc_o, 32'h0);
      chk("ar_cnt",   fetch_count_o, 32'h0);
      chk("ar_vld",   {31'b0, ifid_valid_o}, 32'h0);
      chk("ar_instr", ifid_instr_o, 32'h0000_0013);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
